// File: rtl/avalon_ram_responder.sv
// avalon_ram_responder
// Avalon-MM responder backed by a single-port word RAM. Reads complete with a
// fixed latency of READ_LATENCY cycles through a valid/data shift pipeline.
// Writes update only the byte lanes whose byteenable bit is set.
// Issuing read and write together is illegal: the write is performed, the read
// is dropped, and the sticky protocol_err flag is set until reset.
// Optional feature, enabled by defining RAM_WAIT_STATE_EN: each request is
// stalled for WAIT_CYCLES cycles with avn_waitrequest before it is accepted.

module avalon_ram_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 4096,
    parameter int READ_LATENCY = 1,
    parameter int WAIT_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  avn_read,
    input  logic                  avn_write,
    input  logic [ADDR_WIDTH-1:0] avn_address,
    input  logic [3:0]            avn_byteenable,
    input  logic [31:0]           avn_writedata,
    output logic [31:0]           avn_readdata,
    output logic                  avn_readdatavalid,
    output logic                  avn_waitrequest,
    output logic                  protocol_err
);

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int IDX_MSB = IDX_W + 1;

    // Word index. Byte-offset bits and bits above the RAM depth are ignored,
    // so out-of-range addresses wrap modulo DEPTH_WORDS.
    logic [IDX_W-1:0] idx;
    assign idx = avn_address[IDX_MSB:2];

    logic req;
    assign req = avn_read | avn_write;

    // accept: request completes this cycle; abort: host dropped a stalled request.
    logic accept;
    logic abort;

    // Byte-offset and out-of-range address bits are deliberately not decoded.
    logic unused_addr;
    generate
        if (ADDR_WIDTH > IDX_MSB + 1) begin : g_addr_hi
            assign unused_addr = ^{avn_address[ADDR_WIDTH-1:IDX_MSB+1], avn_address[1:0]};
        end else begin : g_addr_lo
            assign unused_addr = ^avn_address[1:0];
        end
    endgenerate

`ifdef RAM_WAIT_STATE_EN
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_req;

    // Wait-state FSM register; reset parks it in IDLE with the counter cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Wait-state sequencing: stall WAIT_CYCLES cycles, then accept the request.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_req = 1'b0;
        accept   = 1'b0;
        abort    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES > 0) begin
                        wait_req = 1'b1;
                        state_d  = ST_WAIT;
                        cnt_d    = CNT_W'(CNT_INIT);
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    // Host withdrew a stalled request: no access takes place.
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    wait_req = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    accept  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign avn_waitrequest = wait_req;
`else
    // Without wait states every request is accepted in the cycle presented.
    assign accept          = req;
    assign abort           = 1'b0;
    assign avn_waitrequest = 1'b0;

    // WAIT_CYCLES only matters when wait states are compiled in.
    logic unused_cfg;
    assign unused_cfg = (WAIT_CYCLES < 0);
`endif

    // A simultaneous read and write keeps only the write.
    logic rd_accept;
    logic wr_accept;
    assign rd_accept = accept & avn_read & ~avn_write;
    assign wr_accept = accept & avn_write;

    // ------------------------------------------------------------------
    // Word RAM
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word;

    // Byte-lane write at the edge ending the acceptance cycle.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array has no reset; resetting it would prevent mapping
        // onto RAM macros, and its contents are undefined after power-up anyway.
        if (wr_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (avn_byteenable[b]) begin
                    mem[idx][8*b +: 8] <= avn_writedata[8*b +: 8];
                end
            end
        end
    end

    // The array is read in the acceptance cycle, so a write from the previous
    // cycle is already visible to the read that follows it.
    assign rd_word = mem[idx];

    // ------------------------------------------------------------------
    // Read-response pipeline: stage 0 captures the accepted read and the
    // last stage drives the bus, giving exactly READ_LATENCY cycles.
    // ------------------------------------------------------------------
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]             dat_q [READ_LATENCY];
    logic [31:0]             dat_d [READ_LATENCY];

    // Shift valid/data one stage per cycle; data holds while its stage is empty.
    always_comb begin
        vld_d[0] = rd_accept;
        dat_d[0] = rd_accept ? rd_word : dat_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    // Pipeline register; reset flushes reads in flight so they never complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign avn_readdata      = dat_q[READ_LATENCY-1];
    assign avn_readdatavalid = vld_q[READ_LATENCY-1];

    // ------------------------------------------------------------------
    // Sticky protocol error
    // ------------------------------------------------------------------
    logic protocol_err_q, protocol_err_d;

    // Set by read+write collisions or an abandoned stalled request; only rst clears it.
    always_comb begin
        protocol_err_d = protocol_err_q | (avn_read & avn_write) | abort;
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            protocol_err_q <= 1'b0;
        end else begin
            protocol_err_q <= protocol_err_d;
        end
    end

    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_avalon_ram_responder.sv
// Testbench for avalon_ram_responder. Two instances (READ_LATENCY 1 and 3)
// share one stimulus stream; a scoreboard queue per instance holds the
// expected read data and arrival cycle, and monitors compare on each
// readdatavalid pulse.

module tb_avalon_ram_responder;

    localparam int TB_WAIT = 2;
`ifdef RAM_WAIT_STATE_EN
    localparam int EXP_STALLS = TB_WAIT;
`else
    localparam int EXP_STALLS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        avn_read = 1'b0;
    logic        avn_write = 1'b0;
    logic [31:0] avn_address = '0;
    logic [3:0]  avn_byteenable = '0;
    logic [31:0] avn_writedata = '0;

    logic [31:0] rdata_l1, rdata_l3;
    logic        valid_l1, valid_l3;
    logic        wreq_l1, wreq_l3;
    logic        err_l1, err_l3;

    avalon_ram_responder #(
        .ADDR_WIDTH(32), .DEPTH_WORDS(4096), .READ_LATENCY(1), .WAIT_CYCLES(TB_WAIT)
    ) u_lat1 (
        .clk(clk), .rst(rst),
        .avn_read(avn_read), .avn_write(avn_write), .avn_address(avn_address),
        .avn_byteenable(avn_byteenable), .avn_writedata(avn_writedata),
        .avn_readdata(rdata_l1), .avn_readdatavalid(valid_l1),
        .avn_waitrequest(wreq_l1), .protocol_err(err_l1)
    );

    avalon_ram_responder #(
        .ADDR_WIDTH(32), .DEPTH_WORDS(4096), .READ_LATENCY(3), .WAIT_CYCLES(TB_WAIT)
    ) u_lat3 (
        .clk(clk), .rst(rst),
        .avn_read(avn_read), .avn_write(avn_write), .avn_address(avn_address),
        .avn_byteenable(avn_byteenable), .avn_writedata(avn_writedata),
        .avn_readdata(rdata_l3), .avn_readdatavalid(valid_l3),
        .avn_waitrequest(wreq_l3), .protocol_err(err_l3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q_l1[$];
    exp_t        q_l3[$];
    logic [31:0] model [int];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop an expectation on every valid pulse, flag late or spurious ones.
    always @(negedge clk) begin
        exp_t e;
        if (valid_l1 === 1'b1) begin
            if (q_l1.size() == 0) begin
                check("lat1 spurious readdatavalid", valid_l1, 1'b0);
            end else begin
                e = q_l1.pop_front();
                check("lat1 readdata", rdata_l1, e.data);
                check("lat1 response cycle", cyc, e.cyc);
            end
        end
        if (q_l1.size() > 0 && q_l1[0].cyc < cyc) begin
            e = q_l1.pop_front();
            check("lat1 missing readdatavalid", cyc, e.cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid_l3 === 1'b1) begin
            if (q_l3.size() == 0) begin
                check("lat3 spurious readdatavalid", valid_l3, 1'b0);
            end else begin
                e = q_l3.pop_front();
                check("lat3 readdata", rdata_l3, e.data);
                check("lat3 response cycle", cyc, e.cyc);
            end
        end
        if (q_l3.size() > 0 && q_l3[0].cyc < cyc) begin
            e = q_l3.pop_front();
            check("lat3 missing readdatavalid", cyc, e.cyc);
        end
    end

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    // Present a request (called #1 after a rising edge) and hold it until
    // accepted; returns #1 after the edge ending the acceptance cycle with
    // the request still driven, so consecutive calls are back-to-back.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input bit track);
        int          stalls = 0;
        logic        done   = 1'b0;
        logic [31:0] w;
        avn_read       = rd;
        avn_write      = wr;
        avn_address    = addr;
        avn_byteenable = be;
        avn_writedata  = wd;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (!wreq_l1 && !wreq_l3) begin
                done = 1'b1;
                if (wr) begin
                    w = model.exists(widx(addr)) ? model[widx(addr)] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
                    model[widx(addr)] = w;
                end else if (rd && track) begin
                    q_l1.push_back('{data: model[widx(addr)], cyc: cyc + 1});
                    q_l3.push_back('{data: model[widx(addr)], cyc: cyc + 3});
                end
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        check("request accepted", done, 1'b1);
        check("waitrequest stall cycles", stalls, EXP_STALLS);
    endtask

    task automatic idle(input int n);
        avn_read  = 1'b0;
        avn_write = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset readdatavalid l1", valid_l1, 1'b0);
        check("reset readdatavalid l3", valid_l3, 1'b0);
        check("reset readdata l1", rdata_l1, 32'h0);
        check("reset readdata l3", rdata_l3, 32'h0);
        check("reset waitrequest", wreq_l1, 1'b0);
        check("reset protocol_err", err_l1, 1'b0);
        @(posedge clk);
        #1;

        // Full write then immediate read (read-after-write, no stall)
        do_req(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
        do_req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
        // Lane 0 only: 0xDEADBEEF -> 0xDEADBEAA
        do_req(1'b0, 1'b1, 32'h10, 4'h1, 32'h000000AA, 1'b1);
        do_req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
        // Middle lanes: -> 0xDE2233AA
        do_req(1'b0, 1'b1, 32'h10, 4'h6, 32'h11223344, 1'b1);
        do_req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
        idle(4);

        // Four words, then four back-to-back reads returning in order
        do_req(1'b0, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0, 1'b1);
        do_req(1'b0, 1'b1, 32'h4, 4'hF, 32'hB1B1B1B1, 1'b1);
        do_req(1'b0, 1'b1, 32'h8, 4'hF, 32'hC2C2C2C2, 1'b1);
        do_req(1'b0, 1'b1, 32'hC, 4'hF, 32'hD3D3D3D3, 1'b1);
        do_req(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        do_req(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b1);
        do_req(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1);
        do_req(1'b1, 1'b0, 32'hC, 4'h0, 32'h0, 1'b1);
        idle(5);

        // Address wrap: 0x4000 aliases word 0; byte-offset bits ignored
        do_req(1'b0, 1'b1, 32'h4000, 4'hF, 32'h12345678, 1'b1);
        do_req(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        do_req(1'b1, 1'b0, 32'h4002, 4'h0, 32'h0, 1'b1);
        idle(5);
        check("protocol_err clear before collision", err_l3, 1'b0);

        // Illegal read+write: write lands, read dropped, error sticks
        do_req(1'b1, 1'b1, 32'h20, 4'hF, 32'h00000055, 1'b1);
        idle(1);
        check("protocol_err set l1", err_l1, 1'b1);
        check("protocol_err set l3", err_l3, 1'b1);
        do_req(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1);
        idle(5);
        check("protocol_err sticky", err_l1, 1'b1);

        // Reset one cycle after an accepted read: nothing may come back
        do_req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        avn_read = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("protocol_err cleared by rst", err_l1, 1'b0);
        @(posedge clk);
        #1;
        idle(6);

        // RAM survives reset
        do_req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
        idle(5);

`ifdef RAM_WAIT_STATE_EN
        // Withdraw a stalled request: no access, error flagged
        avn_read    = 1'b1;
        avn_address = 32'h10;
        @(posedge clk);
        #1;
        idle(6);
        check("abort sets protocol_err", err_l1, 1'b1);
`endif

        idle(4);
        check("lat1 scoreboard drained", q_l1.size(), 0);
        check("lat3 scoreboard drained", q_l3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
